// File: rtl/join_sync_param.sv
// Clocked N-way four-phase join: sticky per-channel arrival capture, per-channel
// enable masking latched for the duration of a join, and a stall watchdog.
module join_sync_param #(
  parameter int unsigned size    = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [size-1:0] req_in,
  output logic [size-1:0] ack_in,
  input  logic [size-1:0] en_mask,
  output logic            req_out,
  input  logic            ack_out,
  output logic [size-1:0] arrived,
  output logic            busy,
  output logic            timeout
);

  localparam int unsigned   CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    COLLECT,
    FIRE,
    DRAIN,
    RELEASE
  } state_t;

  state_t          state, state_nx;
  logic [size-1:0] mask_lat, mask_lat_nx;
  logic [size-1:0] eff_mask;
  logic [size-1:0] arrived_nx;
  logic [size-1:0] ack_in_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            req_out_nx;
  logic            busy_nx;
  logic            timeout_nx;

  always_comb begin
    state_nx    = state;
    arrived_nx  = arrived;
    mask_lat_nx = mask_lat;
    cnt_nx      = cnt;
    timeout_nx  = timeout;
    eff_mask    = (arrived == '0) ? en_mask : mask_lat;

    case (state)
      COLLECT: begin
        arrived_nx = arrived | (req_in & eff_mask);
        // The mask follows en_mask until the first enabled arrival, then freezes.
        if (arrived == '0) mask_lat_nx = en_mask;
        if ((TIMEOUT != 0) && (arrived != '0)) begin
          if (cnt != CNT_MAX) cnt_nx = cnt + 1'b1;
          if (cnt_nx == CNT_MAX) timeout_nx = 1'b1;
        end
        if ((eff_mask != '0) && (arrived_nx == eff_mask)) begin
          state_nx   = FIRE;
          timeout_nx = 1'b0;
        end
      end
      FIRE: begin
        if (ack_out) state_nx = DRAIN;
      end
      DRAIN: begin
        if ((req_in & mask_lat) == '0) state_nx = RELEASE;
      end
      RELEASE: begin
        if (!ack_out) begin
          state_nx   = COLLECT;
          arrived_nx = '0;
          cnt_nx     = '0;
        end
      end
      default: state_nx = COLLECT;
    endcase

    // Outputs are registered from the next state so each phase change is seen
    // exactly one edge after the input that caused it.
    req_out_nx = (state_nx == FIRE) || (state_nx == DRAIN);
    ack_in_nx  = ((state_nx == DRAIN) || (state_nx == RELEASE)) ? mask_lat_nx : '0;
    busy_nx    = (state_nx != COLLECT) || (arrived_nx != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= COLLECT;
      arrived  <= '0;
      mask_lat <= '0;
      cnt      <= '0;
      timeout  <= 1'b0;
      req_out  <= 1'b0;
      ack_in   <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      arrived  <= arrived_nx;
      mask_lat <= mask_lat_nx;
      cnt      <= cnt_nx;
      timeout  <= timeout_nx;
      req_out  <= req_out_nx;
      ack_in   <= ack_in_nx;
      busy     <= busy_nx;
    end
  end

endmodule

// File: tb/tb_join_sync_param.sv
// Scoreboard bench for join_sync_param (size=4, TIMEOUT=8): each step queues the
// expected {req_out, ack_in, arrived, busy, timeout}; a monitor queues the DUT's.
module tb_join_sync_param;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_in;
  logic [3:0] ack_in;
  logic [3:0] en_mask;
  logic       req_out;
  logic       ack_out;
  logic [3:0] arrived;
  logic       busy;
  logic       timeout;

  join_sync_param #(.size(4), .TIMEOUT(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .req_in (req_in),
    .ack_in (ack_in),
    .en_mask(en_mask),
    .req_out(req_out),
    .ack_out(ack_out),
    .arrived(arrived),
    .busy   (busy),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [10:0] v;
  } exp_t;

  exp_t        exp_q[$];
  logic [10:0] act_q[$];
  logic [10:0] obs;
  int          n_pushed  = 0;
  int          n_sampled = 0;
  int          n_assert  = 0;
  int          n_fail    = 0;

  assign obs = {req_out, ack_in, arrived, busy, timeout};

  always @(posedge clk) begin
    #1;
    if (n_sampled < n_pushed) begin
      act_q.push_back(obs);
      n_sampled++;
    end
  end

  function automatic logic [10:0] mk(input logic ro, input logic [3:0] ai,
                                     input logic [3:0] ar, input logic bz, input logic to);
    return {ro, ai, ar, bz, to};
  endfunction

  task automatic step(input string tag, input logic [10:0] ex);
    exp_t e;
    e.tag = tag;
    e.v   = ex;
    exp_q.push_back(e);
    n_pushed++;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [10:0] a;
    rst = 1'b1; req_in = 4'hF; en_mask = 4'hF; ack_out = 1'b1;
    step("reset_0", mk(0, 4'h0, 4'h0, 0, 0));
    step("reset_1", mk(0, 4'h0, 4'h0, 0, 0));
    rst = 1'b0; req_in = 4'h0; ack_out = 1'b0;
    step("reset_release", mk(0, 4'h0, 4'h0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_assert++;
      if (act_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s: no DUT sample, expected %b", e.tag, e.v);
      end else begin
        a = act_q.pop_front();
        if (a !== e.v) begin
          n_fail++;
          $display("FAIL %s: got %b expected %b {req_out,ack_in,arrived,busy,timeout}", e.tag, a, e.v);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    logic [10:0] a;
    en_mask = 4'hF; req_in = 4'hF; ack_out = 1'b0;
    step("sim_fire_c0", mk(1, 4'h0, 4'hF, 1, 0));
    step("sim_fire_c1", mk(1, 4'h0, 4'hF, 1, 0));
    step("sim_fire_c2", mk(1, 4'h0, 4'hF, 1, 0));
    ack_out = 1'b1;
    step("sim_drain", mk(1, 4'hF, 4'hF, 1, 0));
    req_in = 4'h0;
    step("sim_release", mk(0, 4'hF, 4'hF, 1, 0));
    ack_out = 1'b0;
    step("sim_idle", mk(0, 4'h0, 4'h0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_assert++;
      if (act_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s: no DUT sample, expected %b", e.tag, e.v);
      end else begin
        a = act_q.pop_front();
        if (a !== e.v) begin
          n_fail++;
          $display("FAIL %s: got %b expected %b {req_out,ack_in,arrived,busy,timeout}", e.tag, a, e.v);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [10:0] a;
    req_in = 4'hF; ack_out = 1'b0;
    step("b2b_fire", mk(1, 4'h0, 4'hF, 1, 0));
    ack_out = 1'b1;
    step("b2b_drain", mk(1, 4'hF, 4'hF, 1, 0));
    req_in = 4'h0;
    step("b2b_release", mk(0, 4'hF, 4'hF, 1, 0));
    ack_out = 1'b0;
    step("b2b_idle", mk(0, 4'h0, 4'h0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_assert++;
      if (act_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s: no DUT sample, expected %b", e.tag, e.v);
      end else begin
        a = act_q.pop_front();
        if (a !== e.v) begin
          n_fail++;
          $display("FAIL %s: got %b expected %b {req_out,ack_in,arrived,busy,timeout}", e.tag, a, e.v);
        end
      end
    end
  endtask

  task automatic test_staggered();
    exp_t e;
    logic [10:0] a;
    en_mask = 4'hF; ack_out = 1'b0;
    for (int t = 0; t <= 12; t++) begin
      req_in = {t >= 12, t >= 9, t >= 5, t < 2};
      step($sformatf("stagger_t%0d", t),
           mk(t == 12, 4'h0, {t >= 12, t >= 9, t >= 5, 1'b1}, 1, (t >= 8) && (t < 12)));
    end
    ack_out = 1'b1;
    step("stagger_drain", mk(1, 4'hF, 4'hF, 1, 0));
    req_in = 4'h0;
    step("stagger_release", mk(0, 4'hF, 4'hF, 1, 0));
    ack_out = 1'b0;
    step("stagger_idle", mk(0, 4'h0, 4'h0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_assert++;
      if (act_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s: no DUT sample, expected %b", e.tag, e.v);
      end else begin
        a = act_q.pop_front();
        if (a !== e.v) begin
          n_fail++;
          $display("FAIL %s: got %b expected %b {req_out,ack_in,arrived,busy,timeout}", e.tag, a, e.v);
        end
      end
    end
  endtask

  task automatic test_masking();
    exp_t e;
    logic [10:0] a;
    en_mask = 4'b0101; req_in = 4'b0001; ack_out = 1'b0;
    step("mask_first", mk(0, 4'h0, 4'b0001, 1, 0));
    en_mask = 4'b1111; req_in = 4'b0111;
    step("mask_fire", mk(1, 4'h0, 4'b0101, 1, 0));
    ack_out = 1'b1;
    step("mask_drain", mk(1, 4'b0101, 4'b0101, 1, 0));
    req_in = 4'b1010;
    step("mask_release", mk(0, 4'b0101, 4'b0101, 1, 0));
    req_in = 4'b0000; ack_out = 1'b0;
    step("mask_idle", mk(0, 4'h0, 4'h0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_assert++;
      if (act_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s: no DUT sample, expected %b", e.tag, e.v);
      end else begin
        a = act_q.pop_front();
        if (a !== e.v) begin
          n_fail++;
          $display("FAIL %s: got %b expected %b {req_out,ack_in,arrived,busy,timeout}", e.tag, a, e.v);
        end
      end
    end
  endtask

  task automatic test_watchdog();
    exp_t e;
    logic [10:0] a;
    en_mask = 4'b0011; req_in = 4'b0001; ack_out = 1'b0;
    for (int t = 0; t <= 9; t++)
      step($sformatf("wdog_t%0d", t), mk(0, 4'h0, 4'b0001, 1, t >= 8));
    req_in = 4'b0011;
    step("wdog_fire_clears", mk(1, 4'h0, 4'b0011, 1, 0));
    ack_out = 1'b1;
    step("wdog_drain", mk(1, 4'b0011, 4'b0011, 1, 0));
    req_in = 4'b0000;
    step("wdog_release", mk(0, 4'b0011, 4'b0011, 1, 0));
    ack_out = 1'b0;
    step("wdog_idle", mk(0, 4'h0, 4'h0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_assert++;
      if (act_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s: no DUT sample, expected %b", e.tag, e.v);
      end else begin
        a = act_q.pop_front();
        if (a !== e.v) begin
          n_fail++;
          $display("FAIL %s: got %b expected %b {req_out,ack_in,arrived,busy,timeout}", e.tag, a, e.v);
        end
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    exp_t e;
    logic [10:0] a;
    en_mask = 4'hF; req_in = 4'hF; ack_out = 1'b0;
    step("rstd_fire", mk(1, 4'h0, 4'hF, 1, 0));
    ack_out = 1'b1;
    step("rstd_drain", mk(1, 4'hF, 4'hF, 1, 0));
    rst = 1'b1;
    step("rstd_reset", mk(0, 4'h0, 4'h0, 0, 0));
    rst = 1'b0; req_in = 4'h0; ack_out = 1'b0;
    step("rstd_after", mk(0, 4'h0, 4'h0, 0, 0));
    req_in = 4'hF;
    step("rstd_join_fire", mk(1, 4'h0, 4'hF, 1, 0));
    ack_out = 1'b1;
    step("rstd_join_drain", mk(1, 4'hF, 4'hF, 1, 0));
    req_in = 4'h0;
    step("rstd_join_release", mk(0, 4'hF, 4'hF, 1, 0));
    ack_out = 1'b0;
    step("rstd_join_idle", mk(0, 4'h0, 4'h0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_assert++;
      if (act_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s: no DUT sample, expected %b", e.tag, e.v);
      end else begin
        a = act_q.pop_front();
        if (a !== e.v) begin
          n_fail++;
          $display("FAIL %s: got %b expected %b {req_out,ack_in,arrived,busy,timeout}", e.tag, a, e.v);
        end
      end
    end
  endtask

  task automatic test_mask_zero();
    exp_t e;
    logic [10:0] a;
    en_mask = 4'h0; req_in = 4'hF; ack_out = 1'b0;
    for (int t = 0; t < 50; t++)
      step($sformatf("mask_zero_t%0d", t), mk(0, 4'h0, 4'h0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_assert++;
      if (act_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s: no DUT sample, expected %b", e.tag, e.v);
      end else begin
        a = act_q.pop_front();
        if (a !== e.v) begin
          n_fail++;
          $display("FAIL %s: got %b expected %b {req_out,ack_in,arrived,busy,timeout}", e.tag, a, e.v);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_in = 4'h0; en_mask = 4'h0; ack_out = 1'b0;
    test_reset();
    test_simultaneous();
    test_back_to_back();
    test_staggered();
    test_masking();
    test_watchdog();
    test_reset_mid_drain();
    test_mask_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/join_sync_param.md
# join_sync_param

Clocked, parametrised successor to the asynchronous Muller-gate join. It merges `size` four-phase request/acknowledge channels into a single output channel. Each channel's arrival is captured in a sticky register, so requests need not overlap. Per-channel enable masking lets unused branches be skipped. A watchdog flags joins that stall waiting for a missing branch. It sits at the merge point of forked datapaths in the synchronous version of the handshake library.

## Interface
- `size`, 2: number of input channels (>= 1).
- `TIMEOUT`, 255: watchdog limit in cycles; 0 disables the watchdog.
- `clk`  in  1  sole clock; every register updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req_in`  in  `size`  per-channel four-phase request.
- `ack_in`  out  `size`  per-channel acknowledge.
- `en_mask`  in  `size`  channel enable; 0 means the channel is not waited on and never acknowledged.
- `req_out`  out  1  merged request.
- `ack_out`  in  1  merged acknowledge.
- `arrived`  out  `size`  sticky per-channel arrival status.
- `busy`  out  1  high in any state other than COLLECT, or in COLLECT when `arrived` != 0.
- `timeout`  out  1  sticky watchdog flag.

## Operation
- Reset: state COLLECT. `req_out`=0, `ack_in`=0, `arrived`=0, `timeout`=0, `busy`=0. Watchdog counter = 0. Latched mask = 0.
- Mask latch:
  - While in COLLECT with `arrived`==0, the latched mask tracks `en_mask` every cycle.
  - It freezes on the cycle the first enabled arrival is captured.
  - It is held until the block returns to COLLECT.
- Effective mask is `en_mask` while `arrived`==0, otherwise the latched mask.
- COLLECT:
  - `arrived` <= `arrived` | (`req_in` & effective mask).
  - When the next `arrived` equals the effective mask and the mask != 0, go to FIRE.
  - Arrival is sticky: an enabled `req_in` that drops early stays counted.
- FIRE: `req_out`=1. On `ack_out`==1, go to DRAIN.
- DRAIN:
  - `req_out`=1; `ack_in` = latched mask.
  - When (`req_in` & latched mask)==0, go to RELEASE.
- RELEASE:
  - `req_out`=0; `ack_in` = latched mask.
  - On `ack_out`==0, go to COLLECT and clear `arrived`, `ack_in` and the counter.
- Disabled channels:
  - `ack_in[i]`=0 at all times.
  - `req_in[i]` is ignored.
  - A mask change after the latch has no effect until the next COLLECT.
- All-zero mask: the block stays in COLLECT indefinitely with `req_out`=0. This is not an error.
- Watchdog (`TIMEOUT` > 0):
  - The counter increments each cycle in COLLECT while `arrived` != 0.
  - It saturates at `TIMEOUT`.
  - Reaching `TIMEOUT` sets `timeout`=1.
  - `timeout` clears on entry to FIRE or on `rst`. It does not abort the join.
  - Counter width is $clog2(`TIMEOUT`+1).
- Simultaneous arrivals in one cycle are all captured.
- A new request from a channel during DRAIN or RELEASE is not captured. That channel must wait for COLLECT.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Last required `req_in` sampled high at edge k → `req_out`=1 after edge k (one-cycle latency).
- `ack_out` sampled high at edge k → `ack_in` asserted after edge k.
- All enabled `req_in` sampled low at edge k → `req_out`=0 after edge k.
- `ack_out` sampled low at edge k → `ack_in`=0 and `arrived`=0 after edge k.
- Minimum full handshake at the block: 4 cycles plus the environment response time.
- Back-to-back operation: the next join can capture arrivals on the cycle after RELEASE exits.
- `rst` mid-operation (any state):
  - All state and outputs return to reset values after that edge, regardless of the handshake phase.
  - Environments must re-initialise their channels.
- `timeout` rises after the edge on which the counter reaches `TIMEOUT`: `TIMEOUT` cycles after the first arrival.

## Test plan
- Simultaneous arrival, `size`=4, mask 4'b1111: all `req_in` high at cycle 0 → `req_out`=1 at cycle 1. `ack_out` high at cycle 3 → `ack_in`=4'b1111 at cycle 4. Release all reqs → `req_out`=0 one cycle later. Drop `ack_out` → `ack_in`=0, `busy`=0 one cycle later.
- Staggered arrival: channels 0..3 arrive at cycles 0, 5, 9 and 12, with channel 0 dropping its req at cycle 2 → `arrived` builds 0001, 0011, 0111, 1111 and `req_out` rises at cycle 13.
- Masking, mask 4'b0101: only channels 0 and 2 request → join fires. `ack_in` = 4'b0101 and `ack_in[1]`, `ack_in[3]` never assert. A mask change to 4'b1111 mid-join is ignored until COLLECT.
- Watchdog, `TIMEOUT`=8: channel 0 arrives and channel 1 never does → `timeout`=1 exactly 8 cycles after the arrival. Channel 1 then arrives → FIRE and `timeout` clears.
- Reset mid-DRAIN: `rst` high for one cycle → next cycle `req_out`=0, `ack_in`=0, `arrived`=0, state COLLECT. A subsequent clean join completes normally.
- Mask all zero with requests active → `req_out` stays 0 and `busy` stays 0 for 50 cycles.
